// File: rtl/skin_chroma_xform.sv
`default_nettype none
// ============================================================================
//  Module      : skin_chroma_xform
//  Description : Five-stage luma-dependent chroma transform. Pixels whose luma
//                lies outside [K_L, K_H] have their chroma re-centred around an
//                external LUT mean, scaled by an external LUT width, offset by
//                MEAN_KH and saturated. In-range or bypassed pixels pass
//                through. The pipeline has a single global advance enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module skin_chroma_xform #(
    parameter int DATA_W  = 8,
    parameter int COEF_W  = 16,
    parameter int FRAC    = 8,
    parameter int OUT_W   = 12,
    parameter int K_L     = 125,
    parameter int K_H     = 188,
    parameter int MEAN_KH = 154
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_y,
    input  logic [DATA_W-1:0]        in_c,
    input  logic                     bypass,
    output logic [DATA_W-1:0]        lut_y,
    input  logic signed [COEF_W-1:0] lut_mean,
    input  logic signed [COEF_W-1:0] lut_width,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_c,
    output logic [15:0]              sat_count,
    input  logic                     sat_clear
);

    localparam int DIFF_W = COEF_W + 1;
    localparam int PROD_W = DIFF_W + COEF_W;
    localparam int SUM_W  = PROD_W + 1;

    localparam logic [DATA_W-1:0]       C_K_L     = DATA_W'(K_L);
    localparam logic [DATA_W-1:0]       C_K_H     = DATA_W'(K_H);
    localparam logic signed [SUM_W-1:0] C_MEAN_KH = SUM_W'(MEAN_KH);
    localparam logic signed [OUT_W-1:0] C_OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] C_OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [15:0]             C_SAT_TOP = 16'hFFFF;

    // global advance: a stage moves only when the output slot can be vacated
    logic adv;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    // stage valid bits
    logic v1_q, v2_q, v3_q, v4_q, v5_q;

    // stage data
    logic [DATA_W-1:0]        y1_q, c1_q, c2_q, c3_q, c4_q;
    logic                     pass1_q, pass2_q, pass3_q, pass4_q;
    logic signed [COEF_W-1:0] mean2_q, width2_q, width3_q;
    logic signed [DIFF_W-1:0] diff3_q;
    logic signed [PROD_W-1:0] prod4_q;
    logic                     sat5_q;
    logic signed [OUT_W-1:0]  out_c_q;
    logic [15:0]              sat_count_q;

    // next-state values of the arithmetic stages
    logic                     pass1_d;
    logic signed [DIFF_W-1:0] diff3_d;
    logic signed [PROD_W-1:0] prod_full_d;
    logic signed [PROD_W-1:0] prod4_d;
    logic signed [SUM_W-1:0]  sum_d;
    logic signed [OUT_W-1:0]  out_c_d;
    logic                     sat5_d;

    assign lut_y     = y1_q;
    assign out_valid = v5_q;
    assign out_c     = out_c_q;
    assign sat_count = sat_count_q;

    // arithmetic for every stage: window test, centring, scaling, offset+clamp
    always_comb begin
        pass1_d     = ((in_y >= C_K_L) && (in_y <= C_K_H)) || bypass;
        diff3_d     = $signed({{(DIFF_W-DATA_W){1'b0}}, c2_q}) - DIFF_W'(mean2_q);
        prod_full_d = PROD_W'(diff3_q) * PROD_W'(width3_q);
        prod4_d     = prod_full_d >>> FRAC;
        sum_d       = SUM_W'(prod4_q) + C_MEAN_KH;
        out_c_d     = sum_d[OUT_W-1:0];
        sat5_d      = 1'b0;
        if (pass4_q) begin
            out_c_d = $signed({{(OUT_W-DATA_W){1'b0}}, c4_q});
        end else if (sum_d > SUM_W'(C_OUT_MAX)) begin
            out_c_d = C_OUT_MAX;
            sat5_d  = 1'b1;
        end else if (sum_d < SUM_W'(C_OUT_MIN)) begin
            out_c_d = C_OUT_MIN;
            sat5_d  = 1'b1;
        end
    end

    // valid bits shift together with the data; reset discards in-flight pixels
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            v4_q <= 1'b0;
            v5_q <= 1'b0;
        end else if (adv) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            v4_q <= v3_q;
            v5_q <= v4_q;
        end
    end

    // stage data registers; no reset needed since valid bits qualify them
    always_ff @(posedge clk) begin
        if (adv) begin
            y1_q     <= in_y;
            c1_q     <= in_c;
            pass1_q  <= pass1_d;
            mean2_q  <= lut_mean;
            width2_q <= lut_width;
            c2_q     <= c1_q;
            pass2_q  <= pass1_q;
            diff3_q  <= diff3_d;
            width3_q <= width2_q;
            c3_q     <= c2_q;
            pass3_q  <= pass2_q;
            prod4_q  <= prod4_d;
            c4_q     <= c3_q;
            pass4_q  <= pass3_q;
            sat5_q   <= sat5_d;
        end
    end

    // output register holds while stalled so the consumer sees a stable value
    always_ff @(posedge clk) begin
        if (reset) begin
            out_c_q <= '0;
        end else if (adv) begin
            out_c_q <= out_c_d;
        end
    end

    // saturation counter: counts consumed saturated results, clear has priority
    always_ff @(posedge clk) begin
        if (reset || sat_clear) begin
            sat_count_q <= '0;
        end else if (v5_q && out_ready && sat5_q && (sat_count_q != C_SAT_TOP)) begin
            sat_count_q <= sat_count_q + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_skin_chroma_xform.sv
`default_nettype none
// ============================================================================
//  Module      : tb_skin_chroma_xform
//  Description : Scoreboard bench for skin_chroma_xform with a behavioural
//                reference model and randomized stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_skin_chroma_xform;

    localparam int K_L     = 125;
    localparam int K_H     = 188;
    localparam int MEAN_KH = 154;
    localparam int FRAC_SC = 256;
    localparam int OMAX    = 2047;
    localparam int OMIN    = -2048;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        in_y = '0;
    logic [7:0]        in_c = '0;
    logic              bypass = 1'b0;
    logic [7:0]        lut_y;
    logic signed [15:0] lut_mean;
    logic signed [15:0] lut_width;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic signed [11:0] out_c;
    logic [15:0]       sat_count;
    logic              sat_clear = 1'b0;

    int mean_tab  [256];
    int width_tab [256];

    assign lut_mean  = 16'(mean_tab[lut_y]);
    assign lut_width = 16'(width_tab[lut_y]);

    skin_chroma_xform dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .in_c      (in_c),
        .bypass    (bypass),
        .lut_y     (lut_y),
        .lut_mean  (lut_mean),
        .lut_width (lut_width),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .sat_count (sat_count),
        .sat_clear (sat_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        bit sat;
        int acc_cyc;
        bit lat;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    bit   mon_en    = 1'b0;
    bit   lat_mode  = 1'b0;
    bit   rand_rdy  = 1'b0;
    int   force_stall = 0;
    int   sat_model = 0;
    bit   prev_stall = 1'b0;
    int   held_c    = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // floor division by 2^FRAC, done on plain integers
    function automatic longint floor_div(input longint p);
        if (p >= 0) return p / FRAC_SC;
        return -((-p + FRAC_SC - 1) / FRAC_SC);
    endfunction

    function automatic exp_t model(input int y, input int c, input bit byp);
        exp_t   e;
        longint s;
        e.sat     = 1'b0;
        e.acc_cyc = cyc;
        e.lat     = lat_mode;
        if (byp || (y >= K_L && y <= K_H)) begin
            e.c = c;
        end else begin
            s = floor_div(longint'(c - mean_tab[y]) * longint'(width_tab[y])) + MEAN_KH;
            if (s > OMAX) begin
                e.c = OMAX; e.sat = 1'b1;
            end else if (s < OMIN) begin
                e.c = OMIN; e.sat = 1'b1;
            end else begin
                e.c = int'(s);
            end
        end
        return e;
    endfunction

    // out_ready generator: forced stalls, random back-pressure, or always ready
    always @(posedge clk) begin
        #1;
        if (force_stall > 0) begin
            out_ready = 1'b0;
            force_stall--;
        end else if (rand_rdy) begin
            out_ready = ($urandom % 4) != 0;
        end else begin
            out_ready = 1'b1;
        end
    end

    // monitor: pops the scoreboard on every consumed result
    always @(negedge clk) begin
        if (mon_en) begin
            if (reset) begin
                sat_model  = 0;
                prev_stall = 1'b0;
            end else begin
                exp_t e;
                bit   popped_sat;
                popped_sat = 1'b0;
                check("sat_count", int'(sat_count), sat_model);
                if (prev_stall && out_valid)
                    check("stall_hold", int'(out_c), held_c);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_output: got %0d expected none", int'(out_c));
                    end else begin
                        e = sb.pop_front();
                        check("out_c", int'(out_c), e.c);
                        if (e.lat) check("latency", cyc - e.acc_cyc, 5);
                        popped_sat = e.sat;
                    end
                end
                if (sat_clear) sat_model = 0;
                else if (popped_sat && sat_model != 16'hFFFF) sat_model++;
                prev_stall = out_valid && !out_ready;
                held_c     = int'(out_c);
            end
        end
    end

    task automatic send(input int y, input int c, input bit byp);
        int n;
        in_y = 8'(y); in_c = 8'(c); bypass = byp; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end else begin
            sb.push_back(model(y, c, byp));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mean_tab[i]  = int'($urandom_range(0, 600)) - 300;
            width_tab[i] = int'($urandom_range(0, 1023)) - 512;
            if ($urandom % 8 == 0) width_tab[i] = int'($urandom_range(0, 65535)) - 32768;
        end
        mean_tab[100] = 140;  width_tab[100] = 16'h0180;
        mean_tab[50]  = -500; width_tab[50]  = 16'h7FFF;
        mean_tab[124] = 10;   width_tab[124] = 16'h0200;
        mean_tab[189] = 10;   width_tab[189] = 16'h0200;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_c", int'(out_c), 0);
        check("rst_sat_count", int'(sat_count), 0);
        check("rst_in_ready", int'(in_ready), 1);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // pass-through with latency check
        lat_mode = 1'b1;
        send(150, 140, 1'b0);
        send(100, 160, 1'b0);
        drain();
        lat_mode = 1'b0;

        // saturation then saturation with clear
        send(50, 255, 1'b0);
        drain();
        @(negedge clk);
        check("sat_count_one", int'(sat_count), 1);
        @(posedge clk); #1;
        sat_clear = 1'b1;
        send(50, 255, 1'b0);
        drain();
        @(posedge clk); #1;
        sat_clear = 1'b0;
        @(negedge clk);
        check("sat_count_cleared", int'(sat_count), 0);
        @(posedge clk); #1;

        // luma window edges and bypass
        send(K_L - 1, 100, 1'b0);
        send(K_L,     100, 1'b0);
        send(K_H,     100, 1'b0);
        send(K_H + 1, 100, 1'b0);
        send(50,      77,  1'b1);
        drain();

        // stream of 10 with a 3-cycle stall mid-stream
        for (int i = 0; i < 10; i++) begin
            if (i == 5) force_stall = 3;
            send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0);
        end
        drain();

        // reset with pixels in flight
        for (int i = 0; i < 4; i++)
            send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0);
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", int'(out_valid), 0);
        check("post_rst_in_ready", int'(in_ready), 1);
        repeat (20) @(negedge clk);
        @(posedge clk); #1;

        // randomized traffic with random back-pressure and idle gaps
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 ($urandom % 8) == 0);
            if ($urandom % 5 == 0) begin
                repeat (int'($urandom_range(1, 3))) @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        drain();
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
